// File: rtl/shared_hpc3_mul_gf2n_pipe_pkg.sv
// Shared definitions for the masked GF(2^N) multiplier: share-pair indexing,
// polynomial-basis field multiply and the square-scale helper.
package shared_hpc3_mul_gf2n_pipe_pkg;

    localparam int MAXN = 8;

    // Scale factor applied to the squared term of the fused square-scale product.
    localparam logic [7:0] NU = 8'h09;

    function automatic int npairs(input int shares);
        return shares * (shares - 1) / 2;
    endfunction

    function automatic int pidx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo + hi * (hi - 1) / 2;
    endfunction

    // Reduction polynomial low bits; for N<8 the x^N bit is kept so the xor clears it.
    function automatic logic [7:0] gf2_red(input int n);
        case (n)
            2:       return 8'h07;
            4:       return 8'h13;
            default: return 8'h1b;
        endcase
    endfunction

    function automatic logic [7:0] gf2_mul(input logic [7:0] a, input logic [7:0] b,
                                           input int n);
        logic [7:0] acc;
        logic [7:0] sh;
        logic [7:0] red;
        acc = '0;
        sh  = a;
        red = gf2_red(n);
        for (int k = 0; k < MAXN; k++) begin
            if (k < n) begin
                if (b[k]) acc = acc ^ sh;
                sh = sh[n-1] ? ((sh << 1) ^ red) : (sh << 1);
            end
        end
        return acc;
    endfunction

    function automatic logic [7:0] square_scaler(input logic [7:0] a);
        return gf2_mul(NU, gf2_mul(a, a, 4), 4);
    endfunction

endpackage

// File: rtl/shared_hpc3_mul_gf2n_pipe_hpc3_pair_term.sv
// One ordered share pair (i,j): the blinded cross term FF[i][j] and the
// Z-blinded Y share B[i][j] that is registered before it meets XP_i.
module hpc3_pair_term
    import shared_hpc3_mul_gf2n_pipe_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = 0,
    parameter int ROT  = 0
) (
    input  logic [N-1:0] i_xi,
    input  logic [N-1:0] i_yi,
    input  logic [N-1:0] i_yj,
    input  logic [N-1:0] i_z,
    input  logic [N-1:0] i_r,
    output logic [N-1:0] o_ff,
    output logic [N-1:0] o_b
);

    assign o_b = i_yj ^ i_z;

    generate
        if (MODE == 1 && ROT == 1) begin : g_fused
            // Carries share i's own X_i*Y_i plus its square-scale contribution.
            assign o_ff = N'(gf2_mul(8'(i_xi), 8'(i_z ^ i_yi), N)
                             ^ square_scaler(8'(i_xi ^ i_yi))) ^ i_r;
        end else begin : g_plain
            logic w_unused_yi;
            assign w_unused_yi = ^i_yi;
            assign o_ff = N'(gf2_mul(8'(i_xi), 8'(i_z), N)) ^ i_r;
        end
    endgenerate

endmodule

// File: rtl/shared_hpc3_mul_gf2n_pipe.sv
// Pipelined HPC3-style masked GF(2^N) multiplier with optional fused
// square-scale mode and an optional registered output stage.
module shared_hpc3_mul_gf2n_pipe
    import shared_hpc3_mul_gf2n_pipe_pkg::*;
#(
    parameter int SHARES = 2,
    parameter int N      = 4,
    parameter int MODE   = 0,
    parameter int OUTREG = 0
) (
    input  logic                                ClkxCI,
    input  logic                                RstxBI,
    input  logic                                InValidxSI,
    input  logic [N*SHARES-1:0]                 XxDI,
    input  logic [N*SHARES-1:0]                 YxDI,
    input  logic [N*SHARES*(SHARES-1)/2-1:0]    ZxDI,
    input  logic [N*SHARES*(SHARES-1)/2-1:0]    RxDI,
    output logic [N*SHARES-1:0]                 QxDO,
    output logic                                OutValidxSO
);

    localparam int NPAIRS = npairs(SHARES);

    // Handshake: valid-only, no ready. An input is accepted on every rising
    // edge with InValidxSI=1; OutValidxSO marks the matching result exactly
    // once, 1 (OUTREG=0) or 2 (OUTREG=1) cycles later; the consumer must take it then.

    logic [SHARES-1:0][SHARES-1:0][N-1:0] w_ff;
    logic [SHARES-1:0][SHARES-1:0][N-1:0] w_b;
    logic [SHARES-1:0][SHARES-1:0][N-1:0] r_ff;
    logic [SHARES-1:0][SHARES-1:0][N-1:0] r_b;
    logic [N*SHARES-1:0]                  r_xp;
    logic                                 r_v1;
    logic [N*SHARES-1:0]                  w_q;

    generate
        for (genvar i = 0; i < SHARES; i++) begin : g_row
            for (genvar j = 0; j < SHARES; j++) begin : g_col
                if (i == j) begin : g_diag
                    // In MODE=1 the own-share product lives in the rotated pair term.
                    if (MODE == 0) begin : g_own
                        assign w_ff[i][j] = N'(gf2_mul(8'(XxDI[N*i +: N]),
                                                       8'(YxDI[N*i +: N]), N));
                    end else begin : g_none
                        assign w_ff[i][j] = '0;
                    end
                    assign w_b[i][j] = '0;
                end else begin : g_pair
                    localparam int P   = pidx(i, j);
                    localparam int ROT = (i == (j + 1) % SHARES) ? 1 : 0;
                    hpc3_pair_term #(
                        .N    (N),
                        .MODE (MODE),
                        .ROT  (ROT)
                    ) u_term (
                        .i_xi (XxDI[N*i +: N]),
                        .i_yi (YxDI[N*i +: N]),
                        .i_yj (YxDI[N*j +: N]),
                        .i_z  (ZxDI[N*P +: N]),
                        .i_r  (RxDI[N*P +: N]),
                        .o_ff (w_ff[i][j]),
                        .o_b  (w_b[i][j])
                    );
                end
            end
        end
    endgenerate

    // Stage-1 is the glitch barrier: B must be registered before the XP multiply.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            r_ff <= '0;
            r_b  <= '0;
            r_xp <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= InValidxSI;
            if (InValidxSI) begin
                r_ff <= w_ff;
                r_b  <= w_b;
                r_xp <= XxDI;
            end
        end
    end

    always_comb begin : p_out
        logic [N-1:0] v_ff;
        logic [N-1:0] v_b;
        logic [N-1:0] v_s;
        w_q = '0;
        for (int k = 0; k < SHARES; k++) begin
            v_ff = '0;
            v_b  = '0;
            for (int l = 0; l < SHARES; l++) begin
                v_ff = v_ff ^ r_ff[k][l];
                v_b  = v_b ^ r_b[k][l];
            end
            v_s = v_ff ^ N'(gf2_mul(8'(r_xp[N*k +: N]), 8'(v_b), N));
            for (int jj = 0; jj < N; jj++) begin
                w_q[N*k + jj] = (MODE == 1) ? v_s[(jj + 2) % N] : v_s[jj];
            end
        end
    end

    generate
        if (OUTREG != 0) begin : g_oreg
            logic [N*SHARES-1:0] r_q;
            logic                r_vo;
            always_ff @(posedge ClkxCI or negedge RstxBI) begin
                if (!RstxBI) begin
                    r_q  <= '0;
                    r_vo <= 1'b0;
                end else begin
                    r_vo <= r_v1;
                    if (r_v1) r_q <= w_q;
                end
            end
            assign QxDO        = r_q;
            assign OutValidxSO = r_vo;
        end else begin : g_comb
            assign QxDO        = w_q;
            assign OutValidxSO = r_v1;
        end
    endgenerate

endmodule

// File: tb/tb_shared_hpc3_mul_gf2n_pipe.sv
// Directed bench for the masked GF(2^N) multiplier across three configurations.
module tb_shared_hpc3_mul_gf2n_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // A: SHARES=3, N=4, MODE=0, OUTREG=0
    logic        a_v = 1'b0;
    logic [11:0] a_x = '0, a_y = '0, a_z = '0, a_r = '0, a_q;
    logic        a_ov;
    // B: SHARES=2, N=4, MODE=1, OUTREG=0
    logic        b_v = 1'b0;
    logic [7:0]  b_x = '0, b_y = '0, b_q;
    logic [3:0]  b_z = '0, b_r = '0;
    logic        b_ov;
    // C: SHARES=4, N=8, MODE=0, OUTREG=1
    logic        c_v = 1'b0;
    logic [31:0] c_x = '0, c_y = '0, c_q;
    logic [47:0] c_z = '0, c_r = '0;
    logic        c_ov;

    shared_hpc3_mul_gf2n_pipe #(.SHARES(3), .N(4), .MODE(0), .OUTREG(0)) u_dut_a (
        .ClkxCI(clk), .RstxBI(rst_n), .InValidxSI(a_v), .XxDI(a_x), .YxDI(a_y),
        .ZxDI(a_z), .RxDI(a_r), .QxDO(a_q), .OutValidxSO(a_ov));

    shared_hpc3_mul_gf2n_pipe #(.SHARES(2), .N(4), .MODE(1), .OUTREG(0)) u_dut_b (
        .ClkxCI(clk), .RstxBI(rst_n), .InValidxSI(b_v), .XxDI(b_x), .YxDI(b_y),
        .ZxDI(b_z), .RxDI(b_r), .QxDO(b_q), .OutValidxSO(b_ov));

    shared_hpc3_mul_gf2n_pipe #(.SHARES(4), .N(8), .MODE(0), .OUTREG(1)) u_dut_c (
        .ClkxCI(clk), .RstxBI(rst_n), .InValidxSI(c_v), .XxDI(c_x), .YxDI(c_y),
        .ZxDI(c_z), .RxDI(c_r), .QxDO(c_q), .OutValidxSO(c_ov));

    // GF(2^4), x^4+x+1, hand-computed products
    localparam logic [3:0] AX [12] = '{4'h3, 4'hB, 4'h8, 4'hF, 4'h6, 4'hA,
                                       4'h0, 4'h1, 4'hC, 4'h7, 4'hD, 4'h4};
    localparam logic [3:0] AY [12] = '{4'h7, 4'hB, 4'h8, 4'h2, 4'h9, 4'h5,
                                       4'hB, 4'hE, 4'h3, 4'h7, 4'hE, 4'h4};
    localparam logic [3:0] AE [12] = '{4'h9, 4'h9, 4'hC, 4'hD, 4'h3, 4'h4,
                                       4'h0, 4'hE, 4'h7, 4'h6, 4'hA, 4'h3};
    // Fused square-scale, nu=9, output nibble halves swapped
    localparam logic [3:0] BX [5] = '{4'h5, 4'h1, 4'h2, 4'h7, 4'hA};
    localparam logic [3:0] BY [5] = '{4'h5, 4'h0, 4'h3, 4'h7, 4'h5};
    localparam logic [3:0] BE [5] = '{4'h8, 4'h6, 4'hF, 4'h9, 4'h4};
    // GF(2^8), AES polynomial
    localparam logic [7:0] CX [12] = '{8'h57, 8'h57, 8'h57, 8'h57, 8'h57, 8'h57,
                                       8'h02, 8'h53, 8'hFF, 8'h00, 8'h83, 8'hCA};
    localparam logic [7:0] CY [12] = '{8'h83, 8'h13, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h87, 8'hCA, 8'h01, 8'h77, 8'h57, 8'h53};
    localparam logic [7:0] CE [12] = '{8'hC1, 8'hFE, 8'hAE, 8'h47, 8'h8E, 8'h07,
                                       8'h15, 8'h01, 8'hFF, 8'h00, 8'hC1, 8'h01};

    function automatic logic [3:0] rec_a(input logic [11:0] q);
        return q[3:0] ^ q[7:4] ^ q[11:8];
    endfunction

    function automatic logic [3:0] rec_b(input logic [7:0] q);
        return q[3:0] ^ q[7:4];
    endfunction

    function automatic logic [7:0] rec_c(input logic [31:0] q);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 4; i++) acc = acc ^ q[8*i +: 8];
        return acc;
    endfunction

    task automatic drive_a(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] m0, m1, n0, n1;
        m0 = 4'($urandom); m1 = 4'($urandom);
        n0 = 4'($urandom); n1 = 4'($urandom);
        a_x = {x ^ m0 ^ m1, m1, m0};
        a_y = {y ^ n0 ^ n1, n1, n0};
        a_z = 12'($urandom);
        a_r = 12'($urandom);
        a_v = 1'b1;
    endtask

    task automatic drive_b(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] m0, n0;
        m0 = 4'($urandom); n0 = 4'($urandom);
        b_x = {x ^ m0, m0};
        b_y = {y ^ n0, n0};
        b_z = 4'($urandom);
        b_r = 4'($urandom);
        b_v = 1'b1;
    endtask

    task automatic drive_c(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] sx, sy, m;
        sx = x; sy = y;
        for (int i = 0; i < 3; i++) begin
            m = 8'($urandom); c_x[8*i +: 8] = m; sx = sx ^ m;
            m = 8'($urandom); c_y[8*i +: 8] = m; sy = sy ^ m;
        end
        c_x[31:24] = sx;
        c_y[31:24] = sy;
        c_z = 48'({$urandom, $urandom});
        c_r = 48'({$urandom, $urandom});
        c_v = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++; if (a_q !== 12'h0) begin n_fail++; $display("FAIL reset_a_q: got %h expected 0", a_q); end
        n_checks++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL reset_a_ov: got %b expected 0", a_ov); end
        n_checks++; if (b_q !== 8'h0) begin n_fail++; $display("FAIL reset_b_q: got %h expected 0", b_q); end
        n_checks++; if (b_ov !== 1'b0) begin n_fail++; $display("FAIL reset_b_ov: got %b expected 0", b_ov); end
        n_checks++; if (c_q !== 32'h0) begin n_fail++; $display("FAIL reset_c_q: got %h expected 0", c_q); end
        n_checks++; if (c_ov !== 1'b0) begin n_fail++; $display("FAIL reset_c_ov: got %b expected 0", c_ov); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_pulse();
        @(negedge clk);
        drive_a(4'h0, 4'hB);
        @(negedge clk);
        a_v = 1'b0;
        n_checks++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL pulse_valid: got %b expected 1", a_ov); end
        n_checks++; if (rec_a(a_q) !== 4'h0) begin n_fail++; $display("FAIL pulse_q: got %h expected 0", rec_a(a_q)); end
        @(negedge clk);
        n_checks++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL pulse_valid_drop: got %b expected 0", a_ov); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_q[$];
        logic [3:0] e;
        for (int i = 0; i <= 36; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, a_ov); end
                n_checks++; if (rec_a(a_q) !== e) begin n_fail++; $display("FAIL b2b_q[%0d]: got %h expected %h", i, rec_a(a_q), e); end
            end
            if (i < 36) begin
                drive_a(AX[i % 12], AY[i % 12]);
                exp_q.push_back(AE[i % 12]);
            end else begin
                a_v = 1'b0;
            end
        end
    endtask

    task automatic test_hold();
        logic [11:0] snap;
        @(negedge clk);
        drive_a(4'hD, 4'hE);
        @(negedge clk);
        a_v = 1'b0;
        n_checks++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b expected 1", a_ov); end
        n_checks++; if (rec_a(a_q) !== 4'hA) begin n_fail++; $display("FAIL hold_q: got %h expected a", rec_a(a_q)); end
        snap = a_q;
        for (int i = 0; i < 10; i++) begin
            a_x = 12'($urandom); a_y = 12'($urandom);
            a_z = 12'($urandom); a_r = 12'($urandom);
            @(negedge clk);
            n_checks++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL hold_valid_low[%0d]: got %b expected 0", i, a_ov); end
            n_checks++; if (a_q !== snap) begin n_fail++; $display("FAIL hold_stable[%0d]: got %h expected %h", i, a_q, snap); end
        end
    endtask

    task automatic test_square_scale();
        logic [3:0] exp_q[$];
        logic [3:0] e;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++; if (b_ov !== 1'b1) begin n_fail++; $display("FAIL sqsc_valid[%0d]: got %b expected 1", i, b_ov); end
                n_checks++; if (rec_b(b_q) !== e) begin n_fail++; $display("FAIL sqsc_q[%0d]: got %h expected %h", i, rec_b(b_q), e); end
            end
            if (i < 5) begin
                drive_b(BX[i], BY[i]);
                exp_q.push_back(BE[i]);
            end else begin
                b_v = 1'b0;
            end
        end
    endtask

    task automatic test_outreg_stream();
        logic       vq[$];
        logic [7:0] exp_q[$];
        logic       ev;
        logic [7:0] e;
        int         issued;
        int         cyc;
        issued = 0;
        cyc = 0;
        vq.push_back(1'b0);
        vq.push_back(1'b0);
        while ((issued < 12 || exp_q.size() > 0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            ev = vq.pop_front();
            n_checks++; if (c_ov !== ev) begin n_fail++; $display("FAIL stream_valid[cyc %0d]: got %b expected %b", cyc, c_ov, ev); end
            if (ev) begin
                e = exp_q.pop_front();
                n_checks++; if (rec_c(c_q) !== e) begin n_fail++; $display("FAIL stream_q[cyc %0d]: got %h expected %h", cyc, rec_c(c_q), e); end
            end
            if (issued < 12 && $urandom_range(0, 1) == 1) begin
                drive_c(CX[issued], CY[issued]);
                exp_q.push_back(CE[issued]);
                vq.push_back(1'b1);
                issued++;
            end else begin
                c_v = 1'b0;
                vq.push_back(1'b0);
            end
        end
        c_v = 1'b0;
        n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL stream_timeout: got %0d cycles expected under 200", cyc); end
    endtask

    task automatic test_reset_midpipe();
        @(negedge clk);
        drive_c(8'h57, 8'h83);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (c_q !== 32'h0) begin n_fail++; $display("FAIL midrst_q: got %h expected 0", c_q); end
        n_checks++; if (c_ov !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", c_ov); end
        @(negedge clk);
        c_v = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (c_ov !== 1'b0) begin n_fail++; $display("FAIL midrst_spurious[%0d]: got %b expected 0", i, c_ov); end
            n_checks++; if (c_q !== 32'h0) begin n_fail++; $display("FAIL midrst_q_after[%0d]: got %h expected 0", i, c_q); end
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_back_to_back();
        test_hold();
        test_square_scale();
        test_outreg_stream();
        test_reset_midpipe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shared_hpc3_mul_gf2n_pipe.md
# shared_hpc3_mul_gf2n_pipe

Parametrised, pipelined HPC3-style masked multiplier over GF(2^N), the next generation of the 4-bit square-scale multiplier used in the masked AES S-box inversion. It takes a share count of d+1, a field width, and a fused square-scale mode, and adds a valid handshake. The previous-X share copy is held internally, so callers no longer supply a delayed X input. It sits between the GF(2^8)→GF(2^4) mapping stage and the GF(2^4) inverter of the masked S-box, and is reusable for GF(2^2) and GF(2^8) sub-multipliers.

## Interface
- SHARES, 2: number of Boolean shares; d+1, security order d = SHARES-1.
- N, 4: field width in bits; legal values 2, 4, 8.
- MODE, 0: 0 = plain product; 1 = fused square-scale product, legal only with N=4.
- OUTREG, 0: 1 adds a registered output stage.
- ClkxCI  in  1  clock; all state rising-edge.
- RstxBI  in  1  asynchronous active-low reset.
- InValidxSI  in  1  qualifies XxDI, YxDI, ZxDI and RxDI this cycle.
- XxDI  in  N*SHARES  shares of X; share i occupies bits [N*i +: N].
- YxDI  in  N*SHARES  shares of Y, same packing.
- ZxDI  in  N*SHARES*(SHARES-1)/2  fresh blinding randomness; pair (i<j) at index i + j*(j-1)/2.
- RxDI  in  N*SHARES*(SHARES-1)/2  fresh refresh randomness, same indexing.
- QxDO  out  N*SHARES  product shares.
- OutValidxSO  out  1  QxDO holds a valid result.

## Operation
- Share terms, computed on an accepted input:
  - Off-diagonal pair i≠j: FF[i][j] = X_i·Z_ij ⊕ R_ij.
  - MODE=1, on the pair with i == (j+1) mod SHARES: FF term becomes X_i·(Z_ij ⊕ Y_i) ⊕ ν·(X_i⊕Y_i)².
  - Blinded Y, for each i≠j: B[i][j] = Y_j ⊕ Z_ij.
- Stage-1 registers: FF, B and an internal copy XP of X. All load only when InValidxSI=1. With InValidxSI=0 they hold their contents, so QxDO stays stable.
- Output share k = ⊕_{l≠k} FF[k][l] ⊕ XP_k·(⊕_{l≠k} B[k][l]), computed combinationally from the stage-1 registers.
- MODE=1 output ordering: bit j of output share k is bit (j+2) mod 4 of the internal result.
- Unmasked result, recombined over all shares:
  - MODE=0: Q = X·Y.
  - MODE=1: Q = swap(X·Y ⊕ ν(X⊕Y)²).
- Field arithmetic: polynomial/normal basis identical to gf2_mul at the same N. XOR only, no carries, all widths exactly N.
- The caller supplies fresh Z/R on every accepted input. The block performs no reuse check.

## Timing
- Latency: 1 cycle with OUTREG=0, 2 cycles with OUTREG=1, measured from InValidxSI=1 at edge t. Throughput is one result per cycle.
- OutValidxSO is InValidxSI delayed by the latency.
- With OUTREG=1, the output register loads only when the stage-1 valid bit is 1.
- Reset (RstxBI=0, asynchronous): all FF, B, XP, output and valid registers clear to 0. QxDO = 0 and OutValidxSO = 0 while reset is held.
- Reset asserted mid-pipeline discards in-flight operands. The first valid after deassertion needs a fresh InValidxSI.
- Back-to-back valids overwrite stage 1 each cycle. There is no backpressure; the consumer must sample on OutValidxSO.
- No combinational path from InValidxSI to QxDO. There is a path from the stage-1 registers to QxDO only when OUTREG=0.
- Glitch domain rule: Z-blinded Y must be registered before it is multiplied by XP. Synthesis must not retime across the stage-1 registers.

## Structure
- The shared package provides:
  - the pair index function pidx(i,j) = min + max*(max-1)/2;
  - the per-N gf2_mul constants;
  - the ν constant for square_scaler;
  - localparam NPAIRS = SHARES*(SHARES-1)/2.
- Reuse the existing gf2_mul (#N) and square_scaler. The natural sub-module is hpc3_pair_term, which computes FF[i][j] and B[i][j] for one ordered pair, with MODE handled by generate.
- The top level holds the registers, the valid pipeline and the output XOR trees.

## Test plan
- SHARES=2, N=4, MODE=0, unmasked X=0x0 and Y=0xB with random shares and random Z/R, InValidxSI pulsed once → one cycle later OutValidxSO=1 for exactly one cycle and recombined Q=0x0.
- SHARES=3, N=4, MODE=0, 1000 random (X,Y,Z,R) issued back-to-back → every recombined Q equals the model gf_mul(X,Y) at latency 1, with no gaps.
- SHARES=2, MODE=1, X=Y=0x5 with random masks → recombined Q equals the model swap(gf_mul(5,5) ⊕ ν·0) = swap(5·5).
- InValidxSI=1 once, then held 0 for 10 cycles while XxDI, YxDI, ZxDI and RxDI toggle randomly → QxDO constant and OutValidxSO=0 after the first cycle.
- RstxBI pulled low between input and output (OUTREG=1) → QxDO=0 and OutValidxSO=0 immediately. After release, no spurious valid appears.
- SHARES=4, N=8, OUTREG=1, random stream with InValidxSI duty 50% → results in order at latency 2, each OutValidxSO aligned with its input.
